// File: rtl/spram_fifo_pkg.sv
// spram_fifo_pkg: shared types and sizing helpers for the single-port-RAM FIFO controller
package spram_fifo_pkg;
  typedef enum logic {PRIO_RD, PRIO_WR} prio_t;
  function automatic int count_width(input int addr_width);
    return addr_width + 2;
  endfunction
endpackage

// File: rtl/spram_fifo_obuf.sv
// spram_fifo_obuf: 2-entry output buffer decoupling egress handshake from RAM read latency
module spram_fifo_obuf #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  pop,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] dout,
  output logic [1:0]            count
);
  logic [DATA_WIDTH-1:0] mem [2];
  logic wr_idx, rd_idx;
  always_ff @(posedge clk)
    if (rst) begin
      wr_idx <= 1'b0;
      rd_idx <= 1'b0;
      count  <= 2'd0;
    end else begin
      wr_idx <= wr_idx ^ push;
      rd_idx <= rd_idx ^ pop;
      count  <= count + 2'(push) - 2'(pop);
    end
  always_ff @(posedge clk)
    if (push) mem[wr_idx] <= din;
  assign valid = count != 2'd0;
  // Gate the head so nothing stale is visible while empty
  assign dout  = valid ? mem[rd_idx] : '0;
  always_ff @(posedge clk)
    if (!rst) assert (!(push && !pop && count == 2'd2));
endmodule

// File: rtl/spram_fifo_ctrl.sv
// spram_fifo_ctrl: valid/ready FIFO on one external single-port RAM, arbitrating writes against prefetch reads
module spram_fifo_ctrl
  import spram_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_WIDTH = $clog2(FIFO_DEPTH)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 s_valid,
  output logic                                 s_ready,
  input  logic [DATA_WIDTH-1:0]                s_data,
  output logic                                 m_valid,
  input  logic                                 m_ready,
  output logic [DATA_WIDTH-1:0]                m_data,
  output logic                                 ram_en,
  output logic                                 ram_we,
  output logic [ADDR_WIDTH-1:0]                ram_addr,
  output logic [DATA_WIDTH-1:0]                ram_din,
  input  logic [DATA_WIDTH-1:0]                ram_dout,
  output logic [count_width(ADDR_WIDTH)-1:0]   count,
  output logic                                 full
);
  localparam int CW = count_width(ADDR_WIDTH);
  logic [ADDR_WIDTH:0] wr_ptr, rd_ptr, ram_count;
  logic [1:0] obuf_count;
  logic in_flight, rd_req, wr_elig, contend, grant_rd, wr_fire;
  prio_t prio;
  assign ram_count = wr_ptr - rd_ptr;
  assign full      = ram_count == (ADDR_WIDTH+1)'(FIFO_DEPTH);
  assign wr_elig   = !full;
  // Prefetch only while the output buffer has room for every outstanding word
  assign rd_req    = (ram_count != '0) && ((3'(obuf_count) + 3'(in_flight)) < 3'd2);
  assign contend   = rd_req && s_valid && wr_elig;
  assign grant_rd  = rd_req && !(s_valid && wr_elig && prio == PRIO_WR);
  assign s_ready   = wr_elig && !grant_rd && !rst;
  assign wr_fire   = s_valid && s_ready;
  assign ram_en    = grant_rd || wr_fire;
  assign ram_we    = wr_fire;
  assign ram_addr  = wr_fire ? wr_ptr[ADDR_WIDTH-1:0] : rd_ptr[ADDR_WIDTH-1:0];
  assign ram_din   = s_data;
  assign count     = CW'(ram_count) + CW'(in_flight) + CW'(obuf_count);
  always_ff @(posedge clk)
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      in_flight <= 1'b0;
      prio      <= PRIO_RD;
    end else begin
      wr_ptr    <= wr_ptr + (ADDR_WIDTH+1)'(wr_fire);
      rd_ptr    <= rd_ptr + (ADDR_WIDTH+1)'(grant_rd);
      in_flight <= grant_rd;
      if (contend) prio <= (prio == PRIO_RD) ? PRIO_WR : PRIO_RD;
    end
  spram_fifo_obuf #(.DATA_WIDTH(DATA_WIDTH)) u_obuf (
    .clk   (clk),
    .rst   (rst),
    .push  (in_flight),
    .din   (ram_dout),
    .pop   (m_valid && m_ready),
    .valid (m_valid),
    .dout  (m_data),
    .count (obuf_count)
  );
endmodule

// File: tb/tb_spram_fifo_ctrl.sv
// tb_spram_fifo_ctrl: scoreboard bench for spram_fifo_ctrl with a behavioural single-port RAM
module tb_spram_fifo_ctrl;
  localparam int DW = 8;
  localparam int DEPTH = 16;
  localparam int AW = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic s_valid = 1'b0;
  logic m_ready = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic s_ready, m_valid, ram_en, ram_we, full;
  logic [DW-1:0] m_data, ram_din, ram_dout;
  logic [AW-1:0] ram_addr;
  logic [AW+1:0] count;
  logic [DW-1:0] ram [DEPTH];
  logic [DW-1:0] q [$];
  int vectors = 0, errs = 0, nwr = 0, nrd = 0, nout = 0, max_cnt = 0;
  int acc, w0, r0, o0, got;
  logic [DW-1:0] d;
  logic prev;

  spram_fifo_ctrl #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout), .count(count), .full(full)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (ram_en) begin
      if (ram_we) ram[ram_addr] <= ram_din;
      else ram_dout <= ram[ram_addr];
    end

  task automatic check(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
    vectors++;
    if (got_v !== exp_v) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got_v, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk)
    if (rst) q.delete();
    else begin
      check("count", 32'(count), 32'(q.size()));
      if (int'(count) > max_cnt) max_cnt = int'(count);
      if (ram_en) begin
        if (ram_we) nwr++;
        else nrd++;
      end
      if (s_valid && s_ready) q.push_back(s_data);
      if (m_valid && m_ready) begin
        nout++;
        if (q.size() == 0) check("underflow", 32'(m_valid), 32'd0);
        else check("data", 32'(m_data), 32'(q.pop_front()));
      end
    end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    void'($urandom(32'h5EED_1234));
    rst = 1'b1; s_valid = 1'b1; s_data = 8'h55;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      check("rst_s_ready", 32'(s_ready), 32'd0);
      check("rst_m_valid", 32'(m_valid), 32'd0);
      check("rst_count", 32'(count), 32'd0);
    end
    tick(); rst = 1'b0; s_valid = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 32'(s_ready), 32'd1);
    check("post_rst_full", 32'(full), 32'd0);
    check("post_rst_mdata", 32'(m_data), 32'd0);
    // single word through an empty FIFO
    tick(); s_valid = 1'b1; s_data = 8'hA5; m_ready = 1'b1;
    @(negedge clk);
    check("t0_we", 32'(ram_we), 32'd1);
    check("t0_addr", 32'(ram_addr), 32'd0);
    tick(); s_valid = 1'b0;
    @(negedge clk);
    check("t1_rd_en", 32'(ram_en && !ram_we), 32'd1);
    check("t1_addr", 32'(ram_addr), 32'd0);
    tick(); @(negedge clk);
    check("t2_m_valid", 32'(m_valid), 32'd0);
    tick(); @(negedge clk);
    check("t3_m_valid", 32'(m_valid), 32'd1);
    check("t3_m_data", 32'(m_data), 32'hA5);
    tick(); @(negedge clk);
    check("t4_count", 32'(count), 32'd0);
    // fill with consumer stalled
    tick(); m_ready = 1'b0; s_valid = 1'b1; d = 8'h00; s_data = d; acc = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (s_valid && s_ready) begin acc++; d++; end
      tick(); s_data = d;
    end
    @(negedge clk);
    check("fill_accepted", 32'(acc), 32'd18);
    check("fill_s_ready", 32'(s_ready), 32'd0);
    check("fill_full", 32'(full), 32'd1);
    check("fill_count", 32'(count), 32'd18);
    tick(); s_valid = 1'b0; m_ready = 1'b1; o0 = nout; got = 0;
    for (int i = 0; i < 10 && got == 0; i++) begin
      @(negedge clk);
      if (ram_en && !ram_we) begin
        got = 1;
        check("full_at_first_read", 32'(full), 32'd1);
      end
    end
    check("first_read_seen", 32'(got), 32'd1);
    @(negedge clk);
    check("full_dropped", 32'(full), 32'd0);
    for (int i = 0; i < 40; i++) @(negedge clk);
    check("fill_drained", 32'(nout - o0), 32'd18);
    // contention from a known priority state
    tick(); rst = 1'b1; s_valid = 1'b0; m_ready = 1'b0;
    tick(); rst = 1'b0; s_valid = 1'b1; d = 8'h40; s_data = d; acc = 0;
    for (int i = 0; i < 20 && acc < 4; i++) begin
      @(negedge clk);
      if (s_valid && s_ready) begin acc++; d++; end
      tick(); s_data = d;
      if (acc == 4) s_valid = 1'b0;
    end
    check("prefill", 32'(acc), 32'd4);
    tick(); s_valid = 1'b1; m_ready = 1'b1; w0 = nwr; r0 = nrd; prev = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check("cont_busy", 32'(ram_en), 32'd1);
      if (k >= 3) check("cont_alt", 32'(ram_we), 32'(!prev));
      prev = ram_we;
      if (s_valid && s_ready) d++;
      tick(); s_data = d;
    end
    s_valid = 1'b0;
    check("cont_writes", 32'(nwr - w0), 32'd11);
    check("cont_reads", 32'(nrd - r0), 32'd9);
    for (int i = 0; i < 30; i++) @(negedge clk);
    // random traffic with wrap
    tick(); acc = 0; w0 = nwr;
    s_valid = 1'b1; s_data = 8'($urandom);
    for (int i = 0; i < 3000 && (acc < 64 || q.size() != 0); i++) begin
      @(negedge clk);
      if (s_valid && s_ready) acc++;
      tick();
      s_valid = (acc < 64) && ($urandom_range(0, 3) != 0);
      s_data = 8'($urandom);
      m_ready = $urandom_range(0, 2) != 0;
    end
    s_valid = 1'b0; m_ready = 1'b1;
    check("rnd_accepted", 32'(acc), 32'd64);
    check("rnd_drained", 32'(q.size()), 32'd0);
    check("rnd_wraps", 32'(nwr - w0 >= 48), 32'd1);
    check("max_count", 32'(max_cnt), 32'd18);
    // reset while a read is in flight
    tick(); m_ready = 1'b0; s_valid = 1'b1; d = 8'h90; s_data = d; acc = 0;
    for (int i = 0; i < 20 && acc < 6; i++) begin
      @(negedge clk);
      if (s_valid && s_ready) begin acc++; d++; end
      tick(); s_data = d;
      if (acc == 6) s_valid = 1'b0;
    end
    tick(); tick(); m_ready = 1'b1;
    tick(); m_ready = 1'b0; got = 0;
    for (int i = 0; i < 10 && got == 0; i++) begin
      @(negedge clk);
      if (ram_en && !ram_we) got = 1;
    end
    check("mid_read_seen", 32'(got), 32'd1);
    tick(); rst = 1'b1;
    @(negedge clk);
    check("mid_count", 32'(count), 32'd5);
    tick(); rst = 1'b0;
    @(negedge clk);
    check("mid_rst_count", 32'(count), 32'd0);
    check("mid_rst_m_valid", 32'(m_valid), 32'd0);
    check("mid_rst_m_data", 32'(m_data), 32'd0);
    tick(); s_valid = 1'b1; s_data = 8'h3C; m_ready = 1'b1;
    tick(); s_valid = 1'b0; got = 0;
    for (int i = 0; i < 10 && got == 0; i++) begin
      @(negedge clk);
      if (m_valid) begin
        got = 1;
        check("mid_first_out", 32'(m_data), 32'h3C);
      end
    end
    check("mid_out_seen", 32'(got), 32'd1);
    repeat (5) @(negedge clk);
    check("final_empty", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
